// File: rtl/v1_queue_deserializer.sv
// Packs p_ratio consecutive queue words into one wide word offered over en/rdy.
// Lane 0 holds the oldest word; a flush emits a partial word with its lane count.
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 8
`endif

module v1_queue_deserializer #(
    parameter int unsigned p_bitwidth = `TOP_CHANWIDTH,
    parameter int unsigned p_ratio    = 4,
    parameter int unsigned p_cntwidth = $clog2(p_ratio) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          pop_front_en,
    input  logic                          pop_front_rdy,
    input  logic [p_bitwidth-1:0]         pop_front_data,
    input  logic                          flush_en,
    output logic                          out_rdy,
    input  logic                          out_en,
    output logic [p_bitwidth*p_ratio-1:0] out_data,
    output logic [p_cntwidth-1:0]         out_count
);

    localparam int unsigned OutW = p_bitwidth * p_ratio;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                state;
    logic [p_cntwidth-1:0] cnt;
    logic                  last_lane;

    // Pop path deliberately independent of out_en and flush_en.
    assign pop_front_en = pop_front_rdy && (state == FILL) && !rst;
    assign last_lane    = (cnt == p_cntwidth'(p_ratio - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_rdy   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (pop_front_en) begin
                        for (int unsigned i = 0; i < p_ratio; i++) begin
                            if (cnt == p_cntwidth'(i)) begin
                                out_data[i*p_bitwidth +: p_bitwidth] <= pop_front_data;
                            end
                        end
                        // A same-cycle flush still includes the popped word.
                        if (last_lane || flush_en) begin
                            state     <= FULL;
                            out_rdy   <= 1'b1;
                            out_count <= cnt + p_cntwidth'(1);
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + p_cntwidth'(1);
                        end
                    end else if (flush_en && (cnt != '0)) begin
                        state     <= FULL;
                        out_rdy   <= 1'b1;
                        out_count <= cnt;
                        cnt       <= '0;
                    end
                end
                FULL: begin
                    if (out_en) begin
                        state     <= FILL;
                        out_rdy   <= 1'b0;
                        out_count <= '0;
                        out_data  <= OutW'(0);
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v1_queue_deserializer.sv
// Directed and random checks of v1_queue_deserializer against a word-list model.
module tb_v1_queue_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pop_front_en;
    logic        pop_front_rdy;
    logic [7:0]  pop_front_data;
    logic        flush_en;
    logic        out_rdy;
    logic        out_en;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    v1_queue_deserializer #(.p_bitwidth(8), .p_ratio(4)) dut (
        .clk(clk), .rst(rst),
        .pop_front_en(pop_front_en), .pop_front_rdy(pop_front_rdy),
        .pop_front_data(pop_front_data), .flush_en(flush_en),
        .out_rdy(out_rdy), .out_en(out_en),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cycle    = 0;

    logic [7:0]  src[$];     // queue contents upstream
    logic [7:0]  words[$];   // model: words collected for current output
    bit          m_full;
    bit          prev_rdy;
    int          rises[$];
    logic [31:0] taken[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] w[$]);
        logic [31:0] r = '0;
        foreach (w[i]) r[i*8 +: 8] = w[i];
        return r;
    endfunction

    // One clock: drive inputs, check pop, apply edge to model, check outputs.
    task automatic cyc(input bit fl, input bit oe, input bit gate);
        bit exp_pop;
        flush_en       = fl;
        out_en         = oe;
        pop_front_rdy  = gate && (src.size() > 0);
        pop_front_data = (src.size() > 0) ? src[0] : 8'h00;
        exp_pop        = pop_front_rdy && !m_full;
        #1;
        chk("pop_en", 32'(pop_front_en), 32'(exp_pop));
        if (oe && out_rdy) taken.push_back(out_data);
        @(posedge clk);
        if (m_full) begin
            if (oe) begin
                m_full = 0;
                words.delete();
            end
        end else begin
            if (exp_pop) words.push_back(src[0]);
            if (words.size() == 4 || (fl && words.size() > 0)) m_full = 1;
        end
        if (exp_pop) void'(src.pop_front());
        #1;
        cycle++;
        chk("out_rdy", 32'(out_rdy), 32'(m_full));
        chk("out_count", 32'(out_count), m_full ? 32'(words.size()) : 32'd0);
        chk("out_data", out_data, pack(words));
        if (out_rdy && !prev_rdy) rises.push_back(cycle);
        prev_rdy = out_rdy;
    endtask

    // Assert reset mid-cycle with the queue offering data; check outputs and no pops.
    task automatic do_reset();
        pop_front_rdy  = 1'b1;
        pop_front_data = 8'hEE;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rdy", 32'(out_rdy), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_pop", 32'(pop_front_en), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_pop_hold", 32'(pop_front_en), 32'd0);
        end
        rst = 1'b0;
        words.delete();
        m_full   = 0;
        prev_rdy = 0;
    endtask

    initial begin
        rst = 1'b0; flush_en = 0; out_en = 0; pop_front_rdy = 0; pop_front_data = '0;
        m_full = 0; prev_rdy = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Full word, held while FULL, then a one-word flush.
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        repeat (6) cyc(0, 0, 1);
        chk("full_word", out_data, 32'h44332211);
        chk("full_cnt", 32'(out_count), 32'd4);
        chk("full_nopop", 32'(src.size()), 32'd1);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("one_word", out_data, 32'h00000099);
        cyc(0, 1, 1);

        // Streaming with out_en held high.
        taken.delete(); rises.delete();
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        repeat (11) cyc(0, 1, 1);
        chk("stream_n", 32'(taken.size()), 32'd2);
        if (taken.size() == 2) begin
            chk("stream_w0", taken[0], 32'h04030201);
            chk("stream_w1", taken[1], 32'h08070605);
        end
        if (rises.size() >= 2) chk("stream_gap", 32'(rises[1] - rises[0]), 32'd5);
        else chk("stream_rises", 32'(rises.size()), 32'd2);

        // Partial flush without pop, then flush coinciding with a pop.
        src = '{8'hAA, 8'hBB};
        repeat (2) cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("flush2_data", out_data, 32'h0000BBAA);
        chk("flush2_cnt", 32'(out_count), 32'd2);
        cyc(0, 1, 1);
        src = '{8'hAA, 8'hBB, 8'hCC};
        repeat (2) cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("flush3_data", out_data, 32'h00CCBBAA);
        chk("flush3_cnt", 32'(out_count), 32'd3);
        cyc(0, 1, 1);

        // Ignored flushes and stalled filling.
        cyc(1, 0, 1);
        chk("flush_empty", 32'(out_rdy), 32'd0);
        src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        repeat (4) cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("flush_full", out_data, 32'hD4C3B2A1);
        cyc(0, 1, 1);
        src = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
        chk("stall_word", out_data, 32'h8D7C6B5A);
        cyc(0, 1, 1);

        // Reset in the middle of a fill discards the partial word.
        src = '{8'h55, 8'h66};
        repeat (2) cyc(0, 0, 1);
        do_reset();
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        repeat (4) cyc(0, 0, 1);
        chk("rst_fill_word", out_data, 32'h04030201);
        chk("rst_fill_cnt", 32'(out_count), 32'd4);
        cyc(0, 1, 1);

        // Random traffic, including out_en while not ready.
        for (int i = 0; i < 300; i++) begin
            if (src.size() < 3) src.push_back(8'($urandom));
            cyc(($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
